deglitch_filter_mc: RTL and testbench

DEGLITCH_FILTER_MC -- requirements
Module: deglitch_filter_mc

---
 rtl/deglitch_pkg.sv | 12 +
 rtl/deglitch_ch.sv | 93 +++++++++
 rtl/deglitch_filter_mc.sv | 41 ++++
 tb/tb_deglitch_filter_mc.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/deglitch_pkg.sv
// rtl/deglitch_pkg.sv - shared state encoding and default sizes for the deglitch filter
package deglitch_pkg;

   localparam int NCH_DEF = 2;
   localparam int CW_DEF  = 4;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_QUALIFY = 1'b1
   } state_e;

endpackage

// File: rtl/deglitch_ch.sv
// rtl/deglitch_ch.sv - one filtered channel: 2-flop synchroniser, qualify FSM/counter, edge and glitch pulses
module deglitch_ch
   import deglitch_pkg::*;
#(
   parameter int   CW       = CW_DEF,
   parameter logic INIT_BIT = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_raw,
   input  logic [CW-1:0] flt_len,
   input  logic          byp,
   input  logic          glt_clr,
   output logic          out,
   output logic          rise,
   output logic          fall,
   output logic          glt,
   output logic          glt_flag
);

   logic          s1_q, s1_d;
   logic          s2_q, s2_d;
   logic          out_q, out_d;
   logic [CW-1:0] cnt_q, cnt_d;
   state_e        state_q, state_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic          glt_q, glt_d;
   logic          flag_q, flag_d;
   logic [CW-1:0] len_eff;
   logic [CW:0]   cnt_inc;

   always_comb begin
      s1_d    = in_raw;
      s2_d    = s1_q;
      out_d   = out_q;
      cnt_d   = '0;
      state_d = ST_STABLE;
      glt_d   = 1'b0;
      len_eff = (flt_len == '0) ? CW'(1) : flt_len;
      // One extra bit so count+1 cannot wrap before the compare.
      cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);

      if (byp) begin
         out_d = s2_q;
      end else if (s2_q != out_q) begin
         if (cnt_inc >= {1'b0, len_eff}) begin
            out_d = s2_q;
         end else begin
            cnt_d   = cnt_inc[CW-1:0];
            state_d = ST_QUALIFY;
         end
      end else if (state_q == ST_QUALIFY) begin
         glt_d = 1'b1;
      end

      rise_d = ~out_q & out_d;
      fall_d = out_q & ~out_d;
      // A new glitch wins over a simultaneous clear.
      flag_d = (flag_q & ~glt_clr) | glt_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= INIT_BIT;
         s2_q    <= INIT_BIT;
         out_q   <= INIT_BIT;
         cnt_q   <= '0;
         state_q <= ST_STABLE;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         glt_q   <= 1'b0;
         flag_q  <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         glt_q   <= glt_d;
         flag_q  <= flag_d;
      end
   end

   assign out      = out_q;
   assign rise     = rise_q;
   assign fall     = fall_q;
   assign glt      = glt_q;
   assign glt_flag = flag_q;

endmodule

// File: rtl/deglitch_filter_mc.sv
// rtl/deglitch_filter_mc.sv - multi-channel deglitch filter for I2C SCL/SDA pads
module deglitch_filter_mc
   import deglitch_pkg::*;
#(
   parameter int             NCH  = NCH_DEF,
   parameter int             CW   = CW_DEF,
   parameter logic [NCH-1:0] INIT = {NCH{1'b1}}
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [NCH-1:0] IN,
   input  logic [CW-1:0]  FLT_LEN,
   input  logic           BYP,
   input  logic           GLT_CLR,
   output logic [NCH-1:0] OUT,
   output logic [NCH-1:0] RISE,
   output logic [NCH-1:0] FALL,
   output logic [NCH-1:0] GLT,
   output logic [NCH-1:0] GLT_FLAG
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      deglitch_ch #(
         .CW       (CW),
         .INIT_BIT (INIT[i])
      ) u_ch (
         .clk      (CLK),
         .rst      (RST),
         .in_raw   (IN[i]),
         .flt_len  (FLT_LEN),
         .byp      (BYP),
         .glt_clr  (GLT_CLR),
         .out      (OUT[i]),
         .rise     (RISE[i]),
         .fall     (FALL[i]),
         .glt      (GLT[i]),
         .glt_flag (GLT_FLAG[i])
      );
   end

endmodule

// File: tb/tb_deglitch_filter_mc.sv
// tb/tb_deglitch_filter_mc.sv - directed self-checking bench for deglitch_filter_mc
module tb_deglitch_filter_mc;

   logic       CLK = 1'b0;
   logic       RST;
   logic [1:0] IN;
   logic [3:0] FLT_LEN;
   logic       BYP;
   logic       GLT_CLR;
   logic [1:0] OUT, RISE, FALL, GLT, GLT_FLAG;

   int n_checks = 0;
   int n_errors = 0;
   int glt0_cnt, glt1_cnt, fall0_cnt;

   deglitch_filter_mc dut (
      .CLK      (CLK),
      .RST      (RST),
      .IN       (IN),
      .FLT_LEN  (FLT_LEN),
      .BYP      (BYP),
      .GLT_CLR  (GLT_CLR),
      .OUT      (OUT),
      .RISE     (RISE),
      .FALL     (FALL),
      .GLT      (GLT),
      .GLT_FLAG (GLT_FLAG)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive IN, then advance past the next rising edge; outputs are sampled 1ns later.
   task automatic step(input logic [1:0] in_v);
      IN = in_v;
      @(posedge CLK);
      #1;
   endtask

   task automatic settle(input logic [1:0] in_v);
      FLT_LEN = 4'd1;
      for (int i = 0; i < 6; i++) step(in_v);
   endtask

   initial begin
      RST = 1'b1; IN = 2'b00; FLT_LEN = 4'd3; BYP = 1'b0; GLT_CLR = 1'b0;
      @(posedge CLK); #1;

      // Reset state and first filtered fall
      for (int i = 0; i < 3; i++) step(2'b00);
      check("rst_out", OUT, 2'b11);
      check("rst_pulses", {RISE, FALL, GLT, GLT_FLAG}, 8'h00);
      RST = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         step(2'b00);
         if (k == 3) check("rel_e3_out", {FALL, OUT}, 4'b0011);
         if (k == 4) check("rel_e4_fall", {FALL, OUT}, 4'b1100);
         if (k == 5) check("rel_e5_nofall", FALL, 2'b00);
      end

      // Glitch reject on ch0
      settle(2'b11);
      FLT_LEN = 4'd4;
      glt0_cnt = 0; glt1_cnt = 0;
      for (int k = 0; k <= 8; k++) begin
         step((k < 3) ? 2'b10 : 2'b11);
         glt0_cnt += int'(GLT[0]);
         glt1_cnt += int'(GLT[1]);
         if (OUT !== 2'b11) check("glt_out_held", OUT, 2'b11);
      end
      check("glt_cnt0", glt0_cnt, 1);
      check("glt_cnt1", glt1_cnt, 0);
      check("glt_flag_set", GLT_FLAG, 2'b01);
      GLT_CLR = 1'b1;
      step(2'b11);
      GLT_CLR = 1'b0;
      check("glt_flag_clr", GLT_FLAG, 2'b00);

      // Boundary: exactly N low samples
      glt0_cnt = 0;
      for (int k = 0; k <= 11; k++) begin
         step((k < 4) ? 2'b10 : 2'b11);
         glt0_cnt += int'(GLT[0]);
         if (k == 4) check("bnd_e4_out", OUT, 2'b11);
         if (k == 5) check("bnd_e5_fall", {FALL, OUT}, 4'b0110);
         if (k == 9) check("bnd_e9_rise", {RISE, OUT}, 4'b0111);
      end
      check("bnd_no_glt", glt0_cnt, 0);

      // FLT_LEN = 0 behaves as 1
      FLT_LEN = 4'd0;
      for (int k = 0; k <= 4; k++) begin
         step((k < 1) ? 2'b10 : 2'b11);
         if (k == 1) check("len0_e1_out", OUT, 2'b11);
         if (k == 2) check("len0_e2_fall", {FALL, OUT}, 4'b0110);
         if (k == 3) check("len0_e3_rise", {RISE, OUT}, 4'b0111);
      end

      // Bypass: 1-cycle low pulse on ch1
      FLT_LEN = 4'd4; BYP = 1'b1;
      glt1_cnt = 0;
      for (int k = 0; k <= 5; k++) begin
         step((k < 1) ? 2'b01 : 2'b11);
         glt1_cnt += int'(GLT[0]) + int'(GLT[1]);
         if (k == 1) check("byp_e1_out", OUT, 2'b11);
         if (k == 2) check("byp_e2_fall", {FALL, OUT}, 4'b1001);
         if (k == 3) check("byp_e3_rise", {RISE, OUT}, 4'b1011);
      end
      check("byp_no_glt", glt1_cnt, 0);

      // Bypass raised mid-qualify: abandoned silently
      BYP = 1'b0; FLT_LEN = 4'd8;
      glt1_cnt = 0;
      for (int k = 0; k <= 8; k++) begin
         if (k == 5) BYP = 1'b1;
         step((k < 3) ? 2'b01 : 2'b11);
         glt1_cnt += int'(GLT[0]) + int'(GLT[1]);
         if (OUT !== 2'b11) check("bypq_out_held", OUT, 2'b11);
      end
      check("bypq_no_glt", glt1_cnt, 0);
      check("bypq_no_flag", GLT_FLAG, 2'b00);
      BYP = 1'b0;

      // FLT_LEN lowered mid-qualify
      FLT_LEN = 4'd15;
      for (int k = 0; k <= 8; k++) begin
         if (k == 7) FLT_LEN = 4'd2;
         step(2'b10);
         if (k == 6) check("len_chg_e6", OUT, 2'b11);
         if (k == 7) check("len_chg_e7", {FALL, OUT}, 4'b0110);
      end
      settle(2'b11);

      // Reset mid-qualify
      FLT_LEN = 4'd4;
      for (int k = 0; k <= 2; k++) step(2'b10);
      RST = 1'b1;
      #1;
      check("rstq_out", OUT, 2'b11);
      check("rstq_pulses", {RISE, FALL, GLT, GLT_FLAG}, 8'h00);
      step(2'b11);
      RST = 1'b0;
      glt1_cnt = 0;
      for (int k = 0; k <= 5; k++) begin
         step(2'b11);
         glt1_cnt += int'(|{RISE, FALL, GLT});
      end
      check("rstq_after_out", OUT, 2'b11);
      check("rstq_no_pulse", glt1_cnt, 0);

      // Saturation on ch0 with concurrent glitch on ch1 (clear coincides with glitch)
      FLT_LEN = 4'd15;
      glt0_cnt = 0; glt1_cnt = 0; fall0_cnt = 0;
      for (int k = 0; k <= 22; k++) begin
         GLT_CLR = (k == 3);
         step((k < 1) ? 2'b00 : 2'b10);
         glt0_cnt  += int'(GLT[0]);
         glt1_cnt  += int'(GLT[1]);
         fall0_cnt += int'(FALL[0]);
         if (k == 3)  check("sat_glt1_e3", GLT, 2'b10);
         if (k == 15) check("sat_e15_out", OUT, 2'b11);
         if (k == 16) check("sat_e16_fall", {FALL, OUT}, 4'b0110);
      end
      GLT_CLR = 1'b0;
      check("sat_fall_cnt", fall0_cnt, 1);
      check("sat_out_end", OUT, 2'b10);
      check("sat_glt0", glt0_cnt, 0);
      check("sat_glt1", glt1_cnt, 1);
      check("sat_flag", GLT_FLAG, 2'b10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
